// File: rtl/mw_add_seq.sv
// Multi-word add sequencer.
// Operand words arrive least-significant first, one pair per beat. Each pair
// goes through one W-bit adder. The carry is registered between words, so
// operands of any length add at one word per cycle. A single output register
// holds the sum word together with its index, last marker and flags.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1.
// Once valid is raised, it holds with stable payload until the transfer. Ready
// may depend combinationally on the far side. s_ready = !m_valid || m_ready,
// so a new beat can load in the same cycle that the held beat drains.
module mw_add_seq #(
  parameter int W    = 32,
  parameter int IDXW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_a,
  input  logic [W-1:0]    s_b,
  input  logic            s_cin,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_sum,
  output logic [IDXW-1:0] m_idx,
  output logic            m_last,
  output logic            m_cout,
  output logic            m_ovf,
  output logic            m_zero,
  output logic            busy
);

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_t;

  state_t          state;
  logic            carry_q;
  logic            zacc_q;
  logic [IDXW-1:0] idx_q;

  logic            accept;
  logic            cin_w;
  logic [W:0]      full_w;
  logic            c_msb_in;
  logic            sum_zero;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // The first word takes the external carry-in. Later words chain the registered carry.
  assign cin_w  = (state == FIRST) ? s_cin : carry_q;
  assign full_w = {1'b0, s_a} + {1'b0, s_b} + {{W{1'b0}}, cin_w};

  // Carry into the MSB, recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign c_msb_in = s_a[W-1] ^ s_b[W-1] ^ full_w[W-1];
  assign sum_zero = (full_w[W-1:0] == '0);

  // busy doubles as the observable state of the two-state FSM.
  assign busy = (state == MID);

  // Sequencer state, inter-word carry, word index, zero accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FIRST;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      idx_q   <= '0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_zero  <= 1'b0;
    end else begin
      if (accept) begin
        m_valid <= 1'b1;
        m_sum   <= full_w[W-1:0];
        m_idx   <= idx_q;
        m_last  <= s_last;
        m_cout  <= full_w[W];
        m_ovf   <= s_last & (c_msb_in ^ full_w[W]);
        m_zero  <= s_last & zacc_q & sum_zero;
        if (s_last) begin
          state   <= FIRST;
          carry_q <= 1'b0;
          idx_q   <= '0;
          zacc_q  <= 1'b1;
        end else begin
          state   <= MID;
          carry_q <= full_w[W];
          idx_q   <= idx_q + 1'b1;
          zacc_q  <= zacc_q & sum_zero;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
